// File: rtl/vga_text_console_pkg.sv
// Shared types and constants for the VGA text console writer.
// No logic: enums, geometry defaults and control-code values only.
// Imported by the writer top and its address helper.
package vga_text_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_BLANK,
        ST_CLEAR
    } state_t;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_FF      = 8'h0C;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Attribute used by the clear that follows reset (white on black).
    localparam logic [7:0] RESET_ATTR = 8'h0F;

endpackage

// File: rtl/vga_text_cell_addr.sv
// Purpose: row/col -> linear cell address (row*NUM_COLS + col).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module vga_text_cell_addr #(
    parameter int NUM_COLS = vga_text_console_pkg::COLS
) (
    input  logic [4:0]  row,
    input  logic [6:0]  col,
    output logic [11:0] addr
);
    import vga_text_console_pkg::*;

    if (NUM_COLS == 80) begin : g_shift_add
        // 80 = 64 + 16, so the multiply collapses to two shifts and an add.
        assign addr = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
    end else begin : g_mul
        assign addr = 12'(row * NUM_COLS) + {5'd0, col};
    end

endmodule

// File: rtl/vga_text_console_writer.sv
// Purpose: turns a (char, attr) byte stream into text-card RAM writes with cursor, wrap, scroll, clear.
// Latency: printable char written the cycle after acceptance; scroll 2 cycles/cell, blank and clear 1 cycle/cell.
// Backpressure: in_ready is high only in IDLE; in_valid must hold with stable data until accepted.
module vga_text_console_writer #(
    parameter int         COLS           = vga_text_console_pkg::COLS,
    parameter int         ROWS           = vga_text_console_pkg::ROWS,
    parameter logic [7:0] BLANK_CHAR     = vga_text_console_pkg::BLANK_CHAR,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [7:0]  in_attr,
    output logic        en,
    output logic        we,
    output logic [11:0] addr,
    output logic [15:0] wd,
    input  logic [15:0] rd,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);
    import vga_text_console_pkg::*;

    localparam state_t      RESET_STATE   = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [4:0]  ROW_LAST      = 5'(ROWS - 1);
    localparam logic [6:0]  COL_LAST      = 7'(COLS - 1);
    localparam logic [11:0] COLS_A        = 12'(COLS);
    localparam logic [11:0] CELLS_A       = 12'(COLS * ROWS);
    localparam logic [11:0] SCROLL_LAST   = 12'((ROWS - 1) * COLS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] BLANK_LAST    = 12'(COLS - 1);

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  attr_q, attr_d;
    logic        scroll_q, scroll_d;
    logic        in_ready_q, in_ready_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] wd_q, wd_d;
    logic [11:0] cell_addr;

    vga_text_cell_addr #(.NUM_COLS(COLS)) u_cell_addr (
        .row  (row_q),
        .col  (col_q),
        .addr (cell_addr)
    );

    // Next-state, cursor and bus decode; the bus registers always carry the access of the state being entered.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        attr_d   = attr_q;
        scroll_d = scroll_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wd_d     = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    attr_d = in_attr;
                    if (in_char >= 8'h20) begin
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        addr_d   = cell_addr;
                        wd_d     = {in_attr, in_char};
                        state_d  = ST_PUT;
                        scroll_d = 1'b0;
                        if (col_q == COL_LAST) begin
                            col_d = 7'd0;
                            // On the bottom row the row stays put and the scroll is armed instead.
                            if (row_q == ROW_LAST) scroll_d = 1'b1;
                            else                   row_d    = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (in_char)
                            CH_CR: col_d = 7'd0;
                            CH_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            CH_LF: begin
                                col_d = 7'd0;
                                if (row_q == ROW_LAST) begin
                                    state_d = ST_SCROLL_RD;
                                    cnt_d   = 12'd0;
                                    en_d    = 1'b1;
                                    addr_d  = COLS_A;
                                end else begin
                                    row_d = row_q + 5'd1;
                                end
                            end
                            CH_FF: begin
                                row_d   = 5'd0;
                                col_d   = 7'd0;
                                cnt_d   = 12'd0;
                                state_d = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                if (scroll_q) begin
                    state_d = ST_SCROLL_RD;
                    cnt_d   = 12'd0;
                    en_d    = 1'b1;
                    addr_d  = COLS_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCROLL_RD: begin
                // Write data comes straight from rd during SCROLL_WR (see wd mux below).
                state_d = ST_SCROLL_WR;
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = cnt_q;
            end
            ST_SCROLL_WR: begin
                en_d = 1'b1;
                if (cnt_q == SCROLL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = 12'd0;
                    we_d    = 1'b1;
                    addr_d  = LAST_ROW_BASE;
                    wd_d    = {attr_q, BLANK_CHAR};
                end else begin
                    state_d = ST_SCROLL_RD;
                    cnt_d   = cnt_q + 12'd1;
                    addr_d  = cnt_q + 12'd1 + COLS_A;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d  = cnt_q + 12'd1;
                    en_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = LAST_ROW_BASE + cnt_q + 12'd1;
                    wd_d   = {attr_q, BLANK_CHAR};
                end
            end
            ST_CLEAR: begin
                // cnt is the next cell to issue, so CLEAR also works straight out of reset with the bus idle.
                if (cnt_q == CELLS_A) begin
                    state_d = ST_IDLE;
                end else begin
                    en_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    wd_d   = {attr_q, BLANK_CHAR};
                    cnt_d  = cnt_q + 12'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            row_q      <= 5'd0;
            col_q      <= 7'd0;
            cnt_q      <= 12'd0;
            attr_q     <= RESET_ATTR;
            scroll_q   <= 1'b0;
            in_ready_q <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 12'd0;
            wd_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            attr_q     <= attr_d;
            scroll_q   <= scroll_d;
            in_ready_q <= in_ready_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign en         = en_q;
    assign we         = we_q;
    assign addr       = addr_q;
    // rd is only valid the cycle after the read, so the copy write forwards it unregistered.
    assign wd         = (state_q == ST_SCROLL_WR) ? rd : wd_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Bench for vga_text_console_writer: RAM model plus expected-access scoreboard.
// Every cycle's bus access is popped from the queue and compared.
// Stimulus is a linear sequence of directed steps.
module tb_vga_text_console_writer;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wd;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_attr;
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    logic [15:0] ram [0:4095];
    logic [15:0] shadow [0:2399];
    acc_t        exp_q [$];
    int          exp_row;
    int          exp_col;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    vga_text_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_attr    (in_attr),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    // Text-card RAM: synchronous write, registered read data.
    always @(posedge clk) begin
        if (en && we)  ram[addr] <= wd;
        else if (en)   rd <= ram[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_acc(input logic w, input int a, input logic [15:0] d);
        acc_t e;
        e.we   = w;
        e.addr = 12'(a);
        e.wd   = d;
        exp_q.push_back(e);
    endtask

    task automatic model_clear(input logic [7:0] a);
        for (int i = 0; i < 2400; i++) begin
            push_acc(1'b1, i, {a, 8'h20});
            shadow[i] = {a, 8'h20};
        end
    endtask

    task automatic model_scroll(input logic [7:0] a);
        for (int d = 0; d < 2320; d++) begin
            push_acc(1'b0, d + 80, 16'h0000);
            push_acc(1'b1, d, shadow[d + 80]);
            shadow[d] = shadow[d + 80];
        end
        for (int c = 0; c < 80; c++) begin
            push_acc(1'b1, 2320 + c, {a, 8'h20});
            shadow[2320 + c] = {a, 8'h20};
        end
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        if (c >= 8'h20) begin
            push_acc(1'b1, exp_row * 80 + exp_col, {a, c});
            shadow[exp_row * 80 + exp_col] = {a, c};
            if (exp_col == 79) begin
                exp_col = 0;
                if (exp_row == 29) model_scroll(a);
                else               exp_row++;
            end else begin
                exp_col++;
            end
        end else if (c == 8'h0D) begin
            exp_col = 0;
        end else if (c == 8'h08) begin
            if (exp_col > 0) exp_col--;
        end else if (c == 8'h0A) begin
            exp_col = 0;
            if (exp_row == 29) model_scroll(a);
            else               exp_row++;
        end else if (c == 8'h0C) begin
            exp_row = 0;
            exp_col = 0;
            model_clear(a);
        end
    endtask

    // One clock; sample 1 time unit after the edge and score any bus access.
    task automatic tick();
        acc_t e;
        @(posedge clk);
        #1;
        chk("we_without_en", 32'(we & ~en), 32'd0);
        if (en) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_access observed addr=%0d we=%0d expected no access", addr, we);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bus_we", 32'(we), 32'(e.we));
                chk("bus_addr", 32'(addr), 32'(e.addr));
                if (e.we) chk("bus_wd", 32'(wd), 32'(e.wd));
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!in_ready && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(in_ready), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        bit got;
        got = 1'b0;
        model_byte(c, a);
        in_valid = 1'b1;
        in_char  = c;
        in_attr  = a;
        for (int i = 0; i < 8000 && !got; i++) begin
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("accept", 32'(got), 32'd1);
    endtask

    task automatic chk_cursor(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(cursor_row), 32'(r));
        chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        in_attr  = 8'h00;
        exp_row  = 0;
        exp_col  = 0;

        // Reset state
        tick();
        tick();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk_cursor("rst_cursor", 0, 0);

        // Post-reset clear: 2400 writes of 0F20 in address order
        rst = 1'b0;
        model_clear(8'h0F);
        wait_idle(3000);
        chk("idle_busy", 32'(busy), 32'd0);
        chk_cursor("after_clear", 0, 0);

        // First printable at 0/0
        send(8'h41, 8'h1E);
        chk("put_en", 32'(en), 32'd1);
        chk("put_we", 32'(we), 32'd1);
        chk("put_addr", 32'(addr), 32'd0);
        chk("put_wd", 32'(wd), 32'h1E41);
        chk_cursor("put_cursor", 0, 1);
        chk("put_in_ready", 32'(in_ready), 32'd0);
        wait_idle(10);

        // Fill the rest of row 0; the last write wraps to row 1
        for (int i = 1; i < 80; i++) begin
            send(8'(8'h30 + i), 8'(i));
            wait_idle(10);
        end
        chk("row0_last_cell", 32'(ram[79]), 32'h4F7F);
        chk_cursor("after_row0", 1, 0);

        // Walk down to 29/5
        for (int i = 0; i < 28; i++) begin
            send(8'h0A, 8'h07);
            wait_idle(10);
        end
        send(8'h68, 8'h07); wait_idle(10);
        send(8'h65, 8'h07); wait_idle(10);
        send(8'h6C, 8'h07); wait_idle(10);
        send(8'h6C, 8'h07); wait_idle(10);
        send(8'h6F, 8'h07); wait_idle(10);
        chk_cursor("at_29_5", 29, 5);

        // LF on the bottom row: full scroll then blank the last row
        send(8'h0A, 8'h3C);
        wait_idle(6000);
        chk_cursor("after_lf_scroll", 29, 0);
        chk("scrolled_text", 32'(ram[2240]), 32'h0768);
        chk("blank_row_first", 32'(ram[2320]), 32'h3C20);
        chk("blank_row_last", 32'(ram[2399]), 32'h3C20);

        // BS at col 0 and an ignored control code: no access, cursor unchanged
        send(8'h08, 8'h07); wait_idle(10);
        chk_cursor("bs_col0", 29, 0);
        send(8'h07, 8'h07); wait_idle(10);
        chk_cursor("bel_ignored", 29, 0);

        // BS with col>0 and CR
        send(8'h78, 8'h07); wait_idle(10);
        send(8'h79, 8'h07); wait_idle(10);
        send(8'h08, 8'h07); wait_idle(10);
        chk_cursor("bs_col2", 29, 1);
        send(8'h0D, 8'h07); wait_idle(10);
        chk_cursor("cr", 29, 0);
        chk("bs_no_erase", 32'(ram[2321]), 32'h0779);

        // Form feed: clear with the FF's attribute
        send(8'h0C, 8'h20);
        wait_idle(3000);
        chk_cursor("after_ff", 0, 0);
        chk("ff_cell", 32'(ram[1234]), 32'h2020);

        // Wrap on the bottom-right cell triggers a scroll after the write
        for (int i = 0; i < 29; i++) begin
            send(8'h0A, 8'h20);
            wait_idle(10);
        end
        for (int i = 0; i < 80; i++) begin
            send(8'(8'h30 + i), 8'h5A);
            wait_idle(6000);
        end
        chk_cursor("after_wrap_scroll", 29, 0);
        chk("wrap_scrolled_first", 32'(ram[2240]), 32'h5A30);
        chk("wrap_scrolled_last", 32'(ram[2319]), 32'h5A7F);
        chk("wrap_blank", 32'(ram[2399]), 32'h5A20);

        // Reset in the middle of a scroll
        send(8'h0A, 8'h11);
        for (int i = 0; i < 50; i++) tick();
        chk("mid_scroll_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_we", 32'(we), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst     = 1'b0;
        exp_row = 0;
        exp_col = 0;
        model_clear(8'h0F);
        wait_idle(3000);
        chk_cursor("after_reabort", 0, 0);
        chk("reclear_cell", 32'(ram[0]), 32'h0F20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
